ma_crossover_trader: RTL

- Downstream consumer of the moving-average stage: takes the current price plus a fast and a slow moving average and turns their crossovers into long-only buy/sell decisions.
- Holds position state, entry price, realized profit/loss and a trade count.
- Outputs drive the order/logging logic; all outputs are registered.

---
 rtl/ma_crossover_trader_pkg.sv | 36 +++
 rtl/ma_crossover_trader_pnl_accumulator.sv | 38 +++
 rtl/ma_crossover_trader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ma_crossover_trader_pkg.sv
// Shared types and helpers for the moving-average / crossover datapath.
// Holds width defaults, the trader state enum and a saturating adder.
package ma_crossover_trader_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PNL_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_FLAT   = 2'd1,
    ST_LONG   = 2'd2
  } trade_state_e;

  // Signed add clamped to the range of a w-bit signed value.
  // Callers keep w <= 32 and sign-extend into the 32-bit containers.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int unsigned        w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      return 32'(hi);
    end else if (s < lo) begin
      return 32'(lo);
    end else begin
      return 32'(s);
    end
  endfunction

endpackage

// File: rtl/ma_crossover_trader_pnl_accumulator.sv
// Signed saturating accumulator with enable for realized PnL.
// Ports: clk, reset (sync, high), en, delta (signed), acc (signed).
module pnl_accumulator
  import ma_crossover_trader_pkg::*;
#(
  parameter int PNL_WIDTH   = PNL_WIDTH_DEF,
  parameter int DELTA_WIDTH = DATA_WIDTH_DEF + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic signed [DELTA_WIDTH-1:0] delta,
  output logic signed [PNL_WIDTH-1:0]   acc
);

  logic signed [PNL_WIDTH-1:0] acc_q;
  logic signed [PNL_WIDTH-1:0] acc_d;
  logic signed [31:0]          sum;

  always_comb begin
    sum   = sat_add(32'(acc_q), 32'(delta), PNL_WIDTH);
    acc_d = acc_q;
    if (en) begin
      acc_d = PNL_WIDTH'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ma_crossover_trader.sv
// Long-only crossover trader fed by fast/slow moving averages.
// In: sample_valid, price, fast_avg, slow_avg, flatten. Out: buy/sell
// pulses, position, entry_price, pnl, trade_count, ready (all registered).
module ma_crossover_trader
  import ma_crossover_trader_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int HYST           = 2,
  parameter int WARMUP_SAMPLES = 8,
  parameter int COOLDOWN       = 4,
  parameter int PNL_WIDTH      = PNL_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_valid,
  input  logic [DATA_WIDTH-1:0]       price,
  input  logic [DATA_WIDTH-1:0]       fast_avg,
  input  logic [DATA_WIDTH-1:0]       slow_avg,
  input  logic                        flatten,
  output logic                        buy,
  output logic                        sell,
  output logic                        position,
  output logic [DATA_WIDTH-1:0]       entry_price,
  output logic signed [PNL_WIDTH-1:0] pnl,
  output logic [7:0]                  trade_count,
  output logic                        ready
);

  localparam int WW = $clog2(WARMUP_SAMPLES + 2);
  localparam int CW = $clog2(COOLDOWN + 2);
  localparam int EW = DATA_WIDTH + 1;

  trade_state_e          state_q, state_d;
  logic [WW-1:0]         warm_q, warm_d;
  logic [CW-1:0]         cool_q, cool_d;
  logic                  buy_q, buy_d;
  logic                  sell_q, sell_d;
  logic                  pos_q, pos_d;
  logic [DATA_WIDTH-1:0] entry_q, entry_d;
  logic [7:0]            tc_q, tc_d;
  logic                  rdy_q, rdy_d;

  logic [EW-1:0]         fast_x;
  logic [EW-1:0]         slow_x;
  logic [EW-1:0]         hyst_x;
  logic                  up;
  logic                  down;
  logic [WW-1:0]         warm_inc;
  logic                  cool_zero;
  logic signed [EW-1:0]  delta;

  // One extra bit so adding the margin can never wrap.
  assign fast_x    = {1'b0, fast_avg};
  assign slow_x    = {1'b0, slow_avg};
  assign hyst_x    = EW'(HYST);
  assign up        = fast_x > (slow_x + hyst_x);
  assign down      = (fast_x + hyst_x) < slow_x;
  assign warm_inc  = warm_q + WW'(1);
  assign cool_zero = (cool_q == '0);

  assign delta = $signed({1'b0, price})
               - $signed({1'b0, entry_q});

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cool_d  = cool_q;
    buy_d   = 1'b0;
    sell_d  = 1'b0;
    pos_d   = pos_q;
    entry_d = entry_q;
    tc_d    = tc_q;
    rdy_d   = rdy_q;
    if (sample_valid) begin
      unique case (state_q)
        ST_WARMUP: begin
          warm_d = warm_inc;
          // The completing sample only arms the trader.
          if (warm_inc == WW'(WARMUP_SAMPLES)) begin
            state_d = ST_FLAT;
            rdy_d   = 1'b1;
          end
        end
        ST_FLAT: begin
          if (up && cool_zero && !flatten) begin
            buy_d   = 1'b1;
            entry_d = price;
            pos_d   = 1'b1;
            cool_d  = CW'(COOLDOWN);
            state_d = ST_LONG;
          end else if (!cool_zero) begin
            cool_d = cool_q - CW'(1);
          end
        end
        ST_LONG: begin
          // flatten exits even while cooling down.
          if ((down && cool_zero) || flatten) begin
            sell_d  = 1'b1;
            pos_d   = 1'b0;
            cool_d  = CW'(COOLDOWN);
            state_d = ST_FLAT;
            if (tc_q != 8'hFF) begin
              tc_d = tc_q + 8'd1;
            end
          end else if (!cool_zero) begin
            cool_d = cool_q - CW'(1);
          end
        end
        default: begin
          state_d = ST_WARMUP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WARMUP;
      warm_q  <= '0;
      cool_q  <= '0;
      buy_q   <= 1'b0;
      sell_q  <= 1'b0;
      pos_q   <= 1'b0;
      entry_q <= '0;
      tc_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cool_q  <= cool_d;
      buy_q   <= buy_d;
      sell_q  <= sell_d;
      pos_q   <= pos_d;
      entry_q <= entry_d;
      tc_q    <= tc_d;
      rdy_q   <= rdy_d;
    end
  end

  // Accumulates on the same edge that registers the sell pulse.
  pnl_accumulator #(
    .PNL_WIDTH   (PNL_WIDTH),
    .DELTA_WIDTH (EW)
  ) u_pnl (
    .clk   (clk),
    .reset (reset),
    .en    (sell_d),
    .delta (delta),
    .acc   (pnl)
  );

  assign buy         = buy_q;
  assign sell        = sell_q;
  assign position    = pos_q;
  assign entry_price = entry_q;
  assign trade_count = tc_q;
  assign ready       = rdy_q;

endmodule
